// File: rtl/branch_update_queue.sv
// In-order buffer of branch outcomes resolved in Execute. Each entry is released to the
// predictor as a one-cycle PB_BUS pulse only when its instruction retires in Write-back.
module branch_update_queue #(
  parameter int DEPTH   = 4,
  parameter int CNT_WID = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               E_br_valid,
  input  logic [31:0]        E_br_pc,
  input  logic [31:0]        E_br_inst,
  input  logic               E_br_uncond,
  input  logic               E_br_cond,
  input  logic               E_br_taken,
  input  logic [31:0]        E_br_target,
  input  logic               E_br_mispredict,
  output logic               br_q_full,
  input  logic               W_valid,
  input  logic [31:0]        W_pc,
  input  logic               ex_en,
  input  logic               ertn_flush,
  output logic [98:0]        PB_BUS,
  output logic [CNT_WID-1:0] branch_cnt,
  output logic [CNT_WID-1:0] mispredict_cnt
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        uncond;
    logic        cond;
    logic        taken;
    logic [31:0] target;
    logic        mispredict;
  } entry_t;

  entry_t        entry_mem [DEPTH];
  entry_t        new_entry;
  entry_t        head;
  logic [PW-1:0] wptr_reg;
  logic [PW-1:0] rptr_reg;
  logic [PW:0]   count_reg;
  logic [PW:0]   count_next;
  logic          flush;
  logic          enq;
  logic          commit;

  assign flush     = ex_en | ertn_flush;
  assign br_q_full = (count_reg == (PW+1)'(DEPTH));
  assign new_entry = '{pc: E_br_pc, inst: E_br_inst, uncond: E_br_uncond, cond: E_br_cond,
                       taken: E_br_taken, target: E_br_target, mispredict: E_br_mispredict};
  assign head      = entry_mem[rptr_reg];

  // Full deliberately ignores a same-cycle commit, so an enqueue at full is always rejected.
  assign enq    = E_br_valid & (E_br_uncond | E_br_cond) & ~br_q_full & ~flush;
  assign commit = (count_reg != '0) & W_valid & (W_pc == head.pc) & ~flush;

  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = '0;
    else if (enq && !commit)
      count_next = count_reg + (PW+1)'(1);
    else if (!enq && commit)
      count_next = count_reg - (PW+1)'(1);
  end

  // Storage is not reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (enq)
      entry_mem[wptr_reg] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_reg       <= '0;
      rptr_reg       <= '0;
      count_reg      <= '0;
      PB_BUS         <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      count_reg <= count_next;
      if (flush) begin
        wptr_reg <= '0;
        rptr_reg <= '0;
      end else begin
        if (enq)
          wptr_reg <= wptr_reg + PW'(1);
        if (commit)
          rptr_reg <= rptr_reg + PW'(1);
      end
      // Zero in every non-commit cycle keeps both class bits low, so no predictor write.
      PB_BUS <= commit ? {head.inst, head.uncond, head.cond, head.taken, head.target, head.pc}
                       : '0;
      if (commit) begin
        if (branch_cnt != '1)
          branch_cnt <= branch_cnt + CNT_WID'(1);
        if (head.mispredict && mispredict_cnt != '1)
          mispredict_cnt <= mispredict_cnt + CNT_WID'(1);
      end
    end
  end
endmodule
